alu_issue_ctrl: RTL and testbench

Initiator side of the execute-stage ALU interface.
- Accepts decoded MIPS instruction fields from the decode stage over a valid/ready handshake.
- Translates them to an ALU op code and holds stable operands on the combinational ALU for a programmable number of cycles.
- Captures the ALU result and presents it to writeback over a second valid/ready handshake.
- Flags illegal instructions and unsupported divisors instead of issuing them.

---
 rtl/alu_issue_ctrl_pkg.sv | 38 +++
 rtl/alu_op_decode.sv | 61 ++++++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared datapath width, ALU op codes, MIPS field encodings and FSM states
// for the execute-stage ALU issue controller.
package alu_issue_ctrl_pkg;

  localparam int D_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The ALU divider only handles divide-by-2 and divide-by-4.
  function automatic logic div_ok(input logic [D_WIDTH-1:0] divisor);
    return (divisor[D_WIDTH-1:3] == '0) &&
           ((divisor[2:0] == 3'b010) || (divisor[2:0] == 3'b100));
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of MIPS instruction fields into an ALU op code,
// operand pair, latency class and an illegal/unsupported flag.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic [4:0]         shamt_i,
  input  logic [15:0]        imm_i,
  input  logic [D_WIDTH-1:0] rs_val_i,
  input  logic [D_WIDTH-1:0] rt_val_i,
  output alu_op_e            op_o,
  output logic [D_WIDTH-1:0] opnd1_o,
  output logic [D_WIDTH-1:0] opnd2_o,
  output logic               long_lat_o,
  output logic               err_o
);

  // Field decode; anything not explicitly matched is flagged as an error.
  always_comb begin
    op_o       = ALU_ADD;
    opnd1_o    = rs_val_i;
    opnd2_o    = rt_val_i;
    long_lat_o = 1'b0;
    err_o      = 1'b0;
    case (opcode_i)
      OPC_RTYPE: begin
        case (funct_i)
          FN_ADD:  op_o = ALU_ADD;
          FN_SUB:  op_o = ALU_SUB;
          FN_MULT: begin
            op_o       = ALU_MUL;
            long_lat_o = 1'b1;
          end
          FN_DIV: begin
            op_o       = ALU_DIV;
            long_lat_o = 1'b1;
            err_o      = !div_ok(rt_val_i);
          end
          FN_SLL: begin
            op_o    = ALU_SLL;
            opnd1_o = rt_val_i;
            opnd2_o = {{(D_WIDTH-5){1'b0}}, shamt_i};
          end
          FN_SRL: begin
            op_o    = ALU_SRL;
            opnd1_o = rt_val_i;
            opnd2_o = {{(D_WIDTH-5){1'b0}}, shamt_i};
          end
          default: err_o = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        op_o    = ALU_ADD;
        opnd2_o = {{(D_WIDTH-16){imm_i[15]}}, imm_i};
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage ALU initiator: accepts decoded instructions, holds operands
// on the combinational ALU for a fixed latency, then presents the result.
//
// state   | meaning
// IDLE    | waiting for an instruction, in_ready high
// EXEC    | ALU enabled, operands held, latency counter running down
// DONE    | result/error presented with out_valid until out_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_opcode,
  input  logic [5:0]         in_funct,
  input  logic [4:0]         in_shamt,
  input  logic [15:0]        in_imm,
  input  logic [D_WIDTH-1:0] in_rs_val,
  input  logic [D_WIDTH-1:0] in_rt_val,
  input  logic [4:0]         in_rd,
  output logic [2:0]         alu_op_code,
  output logic [D_WIDTH-1:0] alu_operand1,
  output logic [D_WIDTH-1:0] alu_operand2,
  output logic               alu_enable,
  input  logic [D_WIDTH-1:0] alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] out_result,
  output logic [4:0]         out_rd,
  output logic               out_err
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  state_e             state_q, state_d;
  alu_op_e            op_q, op_d;
  logic [D_WIDTH-1:0] opnd1_q, opnd1_d;
  logic [D_WIDTH-1:0] opnd2_q, opnd2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [D_WIDTH-1:0] result_q, result_d;
  logic [4:0]         rd_q, rd_d;
  logic               err_q, err_d;

  alu_op_e            dec_op;
  logic [D_WIDTH-1:0] dec_opnd1;
  logic [D_WIDTH-1:0] dec_opnd2;
  logic               dec_long;
  logic               dec_err;

  alu_op_decode u_decode (
    .opcode_i   (in_opcode),
    .funct_i    (in_funct),
    .shamt_i    (in_shamt),
    .imm_i      (in_imm),
    .rs_val_i   (in_rs_val),
    .rt_val_i   (in_rt_val),
    .op_o       (dec_op),
    .opnd1_o    (dec_opnd1),
    .opnd2_o    (dec_opnd2),
    .long_lat_o (dec_long),
    .err_o      (dec_err)
  );

  // Next-state logic; a new instruction can be taken in IDLE or while the
  // previous result is being consumed in DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd1_d  = opnd1_q;
    opnd2_d  = opnd2_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_d     = rd_q;
    err_d    = err_q;
    in_ready = 1'b0;

    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          err_d    = 1'b0;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          if (!in_valid) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_ready && in_valid) begin
      rd_d = in_rd;
      if (dec_err) begin
        // Rejected instructions never touch the ALU operand registers.
        err_d    = 1'b1;
        result_d = '0;
        state_d  = ST_DONE;
      end else begin
        op_d    = dec_op;
        opnd1_d = dec_opnd1;
        opnd2_d = dec_opnd2;
        cnt_d   = dec_long ? MUL_CNT : ALU_CNT;
        state_d = ST_EXEC;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_ADD;
      opnd1_q  <= '0;
      opnd2_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd1_q  <= opnd1_d;
      opnd2_q  <= opnd2_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  assign alu_op_code  = op_q;
  assign alu_operand1 = opnd1_q;
  assign alu_operand2 = opnd2_q;
  assign alu_enable   = (state_q == ST_EXEC);
  assign out_valid    = (state_q == ST_DONE);
  assign out_result   = result_q;
  assign out_rd       = rd_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, scoreboard of expected results.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int W = D_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   in_opcode = '0;
  logic [5:0]   in_funct = '0;
  logic [4:0]   in_shamt = '0;
  logic [15:0]  in_imm = '0;
  logic [W-1:0] in_rs_val = '0;
  logic [W-1:0] in_rt_val = '0;
  logic [4:0]   in_rd = '0;
  logic [2:0]   alu_op_code;
  logic [W-1:0] alu_operand1;
  logic [W-1:0] alu_operand2;
  logic         alu_enable;
  logic [W-1:0] alu_result;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [4:0]   out_rd;
  logic         out_err;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   rd;
    logic         err;
    int           en;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   en_cnt = 0;

  alu_issue_ctrl #(.ALU_LAT(1), .MUL_LAT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_funct     (in_funct),
    .in_shamt     (in_shamt),
    .in_imm       (in_imm),
    .in_rs_val    (in_rs_val),
    .in_rt_val    (in_rt_val),
    .in_rd        (in_rd),
    .alu_op_code  (alu_op_code),
    .alu_operand1 (alu_operand1),
    .alu_operand2 (alu_operand2),
    .alu_enable   (alu_enable),
    .alu_result   (alu_result),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (b == '0) ? '0 : a / b;
      3'd4:    return a << b[4:0];
      3'd5:    return a >> b[4:0];
      default: return '0;
    endcase
  endfunction

  // Garbage while disabled exposes any sampling outside EXEC.
  assign alu_result = alu_enable ? alu_f(alu_op_code, alu_operand1, alu_operand2)
                                 : W'(32'hDEAD_BEEF);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] res, input logic [4:0] rd, input logic err,
                              input int en, input logic [2:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b);
    exp_t e;
    e.res = res; e.rd = rd; e.err = err; e.en = en; e.op = op; e.a = a; e.b = b;
    return e;
  endfunction

  // Monitor: checks ALU drive during EXEC and pops the scoreboard on each output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      en_cnt = 0;
    end else begin
      if (alu_enable) begin
        en_cnt++;
        if (exp_q.size() > 0) begin
          chk("alu_op", alu_op_code, exp_q[0].op);
          chk("alu_opnd1", alu_operand1, exp_q[0].a);
          chk("alu_opnd2", alu_operand2, exp_q[0].b);
        end else begin
          chk("alu_en_unexpected", alu_enable, 1'b0);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_result", out_result, e.res);
          chk("out_rd", out_rd, e.rd);
          chk("out_err", out_err, e.err);
          chk("alu_en_cycles", en_cnt, e.en);
          en_cnt = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [W-1:0] rs, input logic [W-1:0] rt,
                      input logic [4:0] rd, input exp_t e, output bit first);
    int  tries = 0;
    bit  done = 0;
    first = 0;
    exp_q.push_back(e);
    in_opcode = opc; in_funct = fn; in_shamt = sh; in_imm = imm;
    in_rs_val = rs; in_rt_val = rt; in_rd = rd; in_valid = 1'b1;
    while (!done && tries < 50) begin
      @(negedge clk);
      if (in_ready) begin
        done  = 1;
        first = (tries == 0);
      end
      tries++;
    end
    if (!done) chk("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    bit first;
    int t;

    // Reset held
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_enable", alu_enable, 1'b0);
    chk("rst_out_result", out_result, '0);
    chk("rst_alu_op", alu_op_code, 3'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    // add 5+7
    send(OPC_RTYPE, FN_ADD, 5'd0, 16'd0, 32'd5, 32'd7, 5'd3,
         mk(32'd12, 5'd3, 1'b0, 1, 3'd0, 32'd5, 32'd7), first);
    drain();
    // addi 10 + (-2)
    send(OPC_ADDI, 6'h00, 5'd0, 16'hFFFE, 32'd10, 32'd0, 5'd5,
         mk(32'd8, 5'd5, 1'b0, 1, 3'd0, 32'd10, 32'hFFFF_FFFE), first);
    drain();
    // sll 1<<4, rs ignored
    send(OPC_RTYPE, FN_SLL, 5'd4, 16'd0, 32'd99, 32'd1, 5'd6,
         mk(32'd16, 5'd6, 1'b0, 1, 3'd4, 32'd1, 32'd4), first);
    drain();
    // srl 0x80>>3
    send(OPC_RTYPE, FN_SRL, 5'd3, 16'd0, 32'd77, 32'h80, 5'd7,
         mk(32'h10, 5'd7, 1'b0, 1, 3'd5, 32'h80, 32'd3), first);
    drain();
    // mult 6*7, three EXEC cycles
    send(OPC_RTYPE, FN_MULT, 5'd0, 16'd0, 32'd6, 32'd7, 5'd8,
         mk(32'd42, 5'd8, 1'b0, 3, 3'd2, 32'd6, 32'd7), first);
    drain();
    // div 40/4
    send(OPC_RTYPE, FN_DIV, 5'd0, 16'd0, 32'd40, 32'd4, 5'd10,
         mk(32'd10, 5'd10, 1'b0, 3, 3'd3, 32'd40, 32'd4), first);
    drain();
    // div by 3 is unsupported
    send(OPC_RTYPE, FN_DIV, 5'd0, 16'd0, 32'd40, 32'd3, 5'd11,
         mk(32'd0, 5'd11, 1'b1, 0, 3'd3, 32'd40, 32'd3), first);
    drain();
    // div by 0x12 (upper bits set) is unsupported
    send(OPC_RTYPE, FN_DIV, 5'd0, 16'd0, 32'd40, 32'h12, 5'd12,
         mk(32'd0, 5'd12, 1'b1, 0, 3'd3, 32'd40, 32'h12), first);
    drain();
    // illegal opcode 0x23: out_valid the very next cycle
    send(6'h23, 6'h20, 5'd0, 16'd0, 32'd1, 32'd2, 5'd13,
         mk(32'd0, 5'd13, 1'b1, 0, 3'd0, 32'd1, 32'd2), first);
    @(negedge clk);
    chk("illegal_next_valid", out_valid, 1'b1);
    chk("illegal_next_err", out_err, 1'b1);
    @(posedge clk); #1;
    drain();
    // illegal R-type funct
    send(OPC_RTYPE, 6'h3F, 5'd0, 16'd0, 32'd1, 32'd2, 5'd14,
         mk(32'd0, 5'd14, 1'b1, 0, 3'd0, 32'd1, 32'd2), first);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(OPC_RTYPE, FN_ADD, 5'd0, 16'd0, 32'd100, 32'd23, 5'd9,
         mk(32'd123, 5'd9, 1'b0, 1, 3'd0, 32'd100, 32'd23), first);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_result", out_result, 32'd123);
      chk("bp_out_rd", out_rd, 5'd9);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    send(OPC_RTYPE, FN_SUB, 5'd0, 16'd0, 32'd9, 32'd4, 5'd4,
         mk(32'd5, 5'd4, 1'b0, 1, 3'd1, 32'd9, 32'd4), first);
    chk("bp_same_cycle_accept", first, 1'b1);
    drain();

    // Back-to-back throughput: second add accepted straight out of DONE
    send(OPC_RTYPE, FN_ADD, 5'd0, 16'd0, 32'd1, 32'd2, 5'd1,
         mk(32'd3, 5'd1, 1'b0, 1, 3'd0, 32'd1, 32'd2), first);
    @(posedge clk); #1;
    send(OPC_RTYPE, FN_SUB, 5'd0, 16'd0, 32'd50, 32'd8, 5'd2,
         mk(32'd42, 5'd2, 1'b0, 1, 3'd1, 32'd50, 32'd8), first);
    chk("b2b_accept_in_done", first, 1'b1);
    drain();

    // Reset during EXEC drops the in-flight mult
    send(OPC_RTYPE, FN_MULT, 5'd0, 16'd0, 32'd3, 32'd3, 5'd15,
         mk(32'd9, 5'd15, 1'b0, 3, 3'd2, 32'd3, 32'd3), first);
    @(negedge clk);
    chk("pre_rst_exec", alu_enable, 1'b1);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_alu_enable", alu_enable, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("after_rst_out_valid", out_valid, 1'b0);
    end
    chk("after_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Block still works after reset
    send(OPC_RTYPE, FN_ADD, 5'd0, 16'd0, 32'd20, 32'd22, 5'd3,
         mk(32'd42, 5'd3, 1'b0, 1, 3'd0, 32'd20, 32'd22), first);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
